// File: rtl/microcode_pkg.sv
// Shared types and helpers for the microcode fetch unit.
//   instr_w()       : instruction width derived from the register-file address width
//   fetch_state_t   : fetch FSM encoding
//   FIFO_DEPTH_MIN  : smallest buffer depth that sustains one instruction per cycle
package microcode_pkg;

   localparam int unsigned FIFO_DEPTH_MIN = 3;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

   // Opcode field is 5 bits, followed by two register-file addresses.
   function automatic int unsigned instr_w(input int unsigned rf_address_bits);
      return 32'd5 + (32'd2 * rf_address_bits);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {addr, data} entries feeding the decoder.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   push, push_addr/data: write an entry at the tail
//   pop                 : retire the head entry
//   flush               : drop every buffered entry (wins over push/pop)
//   count               : number of valid entries
//   head_addr/data      : head entry, stable until popped or flushed
module fetch_fifo #(
   parameter  int unsigned DEPTH = 3,
   parameter  int unsigned AW    = 6,
   parameter  int unsigned DW    = 11,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [AW-1:0]    push_addr,
   input  logic [DW-1:0]    push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [CNT_W-1:0] count,
   output logic [AW-1:0]    head_addr,
   output logic [DW-1:0]    head_data
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned EW    = AW + DW;

   logic [EW-1:0]    mem_q [DEPTH];
   logic [EW-1:0]    mem_d [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      // A push into a full buffer is only accepted if the head leaves the same cycle.
      do_push = push && ((count_q != CNT_W'(DEPTH)) || pop);
      do_pop  = pop && (count_q != '0);
      if (flush) begin
         wr_d    = '0;
         rd_d    = '0;
         count_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = {push_addr, push_data};
            wr_d        = ptr_inc(wr_q);
         end
         if (do_pop) begin
            rd_d = ptr_inc(rd_q);
         end
         if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   // State registers; storage is cleared so the head reads zero out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   assign count                  = count_q;
   assign {head_addr, head_data} = mem_q[rd_q];

endmodule

// File: rtl/microcode_fetch.sv
// Microcode fetch unit: reads a synchronous ROM and streams instructions,
// with their addresses, to the decoder over a valid/ready handshake.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   start, start_address         : leave IDLE and fetch from start_address
//   stop                         : abort fetching, flush, return to IDLE
//   branch_valid, branch_target  : redirect fetch (flushes buffered words)
//   ROM_readEnable, ROM_address  : ROM read strobe and address
//   ROM_data                     : ROM word, valid the cycle after a strobe
//   instr_valid/ready/data/addr  : decoder handshake and payload
//   busy                         : high while fetching (RUN)
// FIFO_DEPTH must be at least microcode_pkg::FIFO_DEPTH_MIN for full throughput.
module microcode_fetch
   import microcode_pkg::*;
#(
   parameter  int unsigned ROM_addressBits = 6,
   parameter  int unsigned RF_addressBits  = 3,
   parameter  int unsigned FIFO_DEPTH      = 3,
   localparam int unsigned INSTR_W         = instr_w(RF_addressBits)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [ROM_addressBits-1:0] start_address,
   input  logic                       stop,
   input  logic                       branch_valid,
   input  logic [ROM_addressBits-1:0] branch_target,
   output logic                       ROM_readEnable,
   output logic [ROM_addressBits-1:0] ROM_address,
   input  logic [INSTR_W-1:0]         ROM_data,
   output logic                       instr_valid,
   input  logic                       instr_ready,
   output logic [INSTR_W-1:0]         instr_data,
   output logic [ROM_addressBits-1:0] instr_addr,
   output logic                       busy
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   fetch_state_t               state_q, state_d;
   logic [ROM_addressBits-1:0] pc_q, pc_d;
   logic                       pend_q, pend_d;
   logic [ROM_addressBits-1:0] pend_addr_q, pend_addr_d;

   logic                       rd_en;
   logic [ROM_addressBits-1:0] rd_addr;
   logic                       flush;
   logic                       push;
   logic                       pop;
   logic                       credit_ok;
   logic [CNT_W-1:0]           fifo_count;

   // Issue only if the word in flight plus the new one still fit; a same-cycle
   // pop is deliberately not credited, which keeps this path short.
   assign credit_ok = (32'(fifo_count) + 32'(pend_q) + 32'd1) <= FIFO_DEPTH;

   // FSM next-state, PC update and read issue.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pend_d      = 1'b0;
      pend_addr_d = pend_addr_q;
      rd_en       = 1'b0;
      rd_addr     = pc_q;
      flush       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               pc_d    = start_address;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
               flush   = 1'b1;
            end else if (branch_valid) begin
               // Buffer is emptied this cycle, so the target read always has room.
               flush       = 1'b1;
               rd_en       = 1'b1;
               rd_addr     = branch_target;
               pc_d        = branch_target + ROM_addressBits'(1);
               pend_d      = 1'b1;
               pend_addr_d = branch_target;
            end else if (credit_ok) begin
               rd_en       = 1'b1;
               pc_d        = pc_q + ROM_addressBits'(1);
               pend_d      = 1'b1;
               pend_addr_d = pc_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Word returning from the previous strobe is captured unless it was flushed.
   assign push = pend_q && !flush;
   assign pop  = instr_valid && instr_ready && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         pc_q        <= '0;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .AW    (ROM_addressBits),
      .DW    (INSTR_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_addr (pend_addr_q),
      .push_data (ROM_data),
      .pop       (pop),
      .flush     (flush),
      .count     (fifo_count),
      .head_addr (instr_addr),
      .head_data (instr_data)
   );

   assign ROM_readEnable = rd_en;
   assign ROM_address    = rd_addr;
   // The branch cycle voids the handshake so stale words are never accepted.
   assign instr_valid    = (fifo_count != '0) && !branch_valid;
   assign busy           = (state_q == RUN);

endmodule

// File: tb/tb_microcode_fetch.sv
// Bench for microcode_fetch: directed stimulus, expected instructions queued
// by the stimulus thread and checked by an independent handshake monitor.
module tb_microcode_fetch;

   localparam int unsigned AW = 6;
   localparam int unsigned DW = 11;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          start;
   logic [AW-1:0] start_address;
   logic          stop;
   logic          branch_valid;
   logic [AW-1:0] branch_target;
   logic          ROM_readEnable;
   logic [AW-1:0] ROM_address;
   logic [DW-1:0] ROM_data;
   logic          instr_valid;
   logic          instr_ready;
   logic [DW-1:0] instr_data;
   logic [AW-1:0] instr_addr;
   logic          busy;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];

   microcode_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .start_address  (start_address),
      .stop           (stop),
      .branch_valid   (branch_valid),
      .branch_target  (branch_target),
      .ROM_readEnable (ROM_readEnable),
      .ROM_address    (ROM_address),
      .ROM_data       (ROM_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_data     (instr_data),
      .instr_addr     (instr_addr),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM: ROM[i] = i + 100.
   initial ROM_data = '0;
   always @(posedge clk) begin
      if (ROM_readEnable) ROM_data <= DW'(ROM_address) + DW'(100);
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic push_exp(input int a);
      exp_t e;
      e.addr = AW'(a);
      e.data = DW'(a + 100);
      exp_q.push_back(e);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted instruction must match the scoreboard head.
   always @(negedge clk) begin
      if (!rst && instr_valid && instr_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL deliver_unexpected got addr=%0d data=%0d want none", instr_addr, instr_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (instr_addr !== e.addr || instr_data !== e.data) begin
               bad++;
               $display("FAIL deliver got addr=%0d data=%0d want addr=%0d data=%0d",
                        instr_addr, instr_data, e.addr, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rd_en"},  32'(ROM_readEnable), 0);
      chk({tag, "_rd_addr"}, 32'(ROM_address),   0);
      chk({tag, "_valid"},  32'(instr_valid),    0);
      chk({tag, "_data"},   32'(instr_data),     0);
      chk({tag, "_iaddr"},  32'(instr_addr),     0);
      chk({tag, "_busy"},   32'(busy),           0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start_address = '0; stop = 1'b0;
      branch_valid = 1'b0; branch_target = '0; instr_ready = 1'b0;
      #3;
      chk_reset_vals("rst0");
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;

      // Basic stream from address 0.
      nxt(); start = 1'b1; start_address = 6'd0; instr_ready = 1'b1;
      for (int a = 0; a <= 5; a++) push_exp(a);
      #1; chk("t1_no_strobe_c0", 32'(ROM_readEnable), 0); chk("t1_busy_c0", 32'(busy), 0);
      nxt(); start = 1'b0;
      #1; chk("t1_strobe_c1", 32'(ROM_readEnable), 1); chk("t1_addr_c1", 32'(ROM_address), 0);
      chk("t1_busy_c1", 32'(busy), 1);
      nxt(); #1; chk("t1_addr_c2", 32'(ROM_address), 1);
      nxt(); #1; chk("t1_valid_c3", 32'(instr_valid), 1);
      repeat (5) nxt();
      nxt(); instr_ready = 1'b0;
      nxt(); stop = 1'b1;
      nxt(); stop = 1'b0;
      #1; chk("t1_busy_stop", 32'(busy), 0); chk("t1_rd_stop", 32'(ROM_readEnable), 0);
      chk("t1_valid_stop", 32'(instr_valid), 0);
      chk("t1_drain", 32'(exp_q.size()), 0);

      // Back-pressure: buffer saturates, strobe drops, head held.
      nxt(); start = 1'b1; start_address = 6'd0; instr_ready = 1'b0;
      for (int a = 0; a <= 6; a++) push_exp(a);
      nxt(); start = 1'b0;
      repeat (3) nxt();
      #1; chk("t2_strobe_drop_c4", 32'(ROM_readEnable), 0); chk("t2_valid_c4", 32'(instr_valid), 1);
      chk("t2_data_c4", 32'(instr_data), 100);
      repeat (8) nxt();
      #1; chk("t2_strobe_drop_c12", 32'(ROM_readEnable), 0); chk("t2_data_c12", 32'(instr_data), 100);
      chk("t2_iaddr_c12", 32'(instr_addr), 0);
      nxt(); instr_ready = 1'b1;
      #1; chk("t2_valid_c13", 32'(instr_valid), 1);
      for (int i = 1; i <= 3; i++) begin
         nxt(); #1;
         chk("t2_nogap_valid", 32'(instr_valid), 1);
         chk("t2_nogap_addr", 32'(instr_addr), 32'(i));
      end
      repeat (3) nxt();
      nxt(); instr_ready = 1'b0;
      nxt(); stop = 1'b1;
      nxt(); stop = 1'b0;
      #1; chk("t2_drain", 32'(exp_q.size()), 0);

      // Branch to 40 while words 5 and 6 are buffered.
      nxt(); start = 1'b1; start_address = 6'd0; instr_ready = 1'b1;
      for (int a = 0; a <= 4; a++) push_exp(a);
      for (int a = 40; a <= 42; a++) push_exp(a);
      nxt(); start = 1'b0;
      repeat (6) nxt();
      nxt(); instr_ready = 1'b0;
      nxt(); branch_valid = 1'b1; branch_target = 6'd40; instr_ready = 1'b1;
      #1; chk("t3_valid_branch", 32'(instr_valid), 0); chk("t3_strobe_branch", 32'(ROM_readEnable), 1);
      chk("t3_addr_branch", 32'(ROM_address), 40);
      nxt(); branch_valid = 1'b0;
      #1; chk("t3_valid_b1", 32'(instr_valid), 0); chk("t3_addr_b1", 32'(ROM_address), 41);
      nxt(); #1; chk("t3_valid_b2", 32'(instr_valid), 1); chk("t3_iaddr_b2", 32'(instr_addr), 40);
      repeat (2) nxt();
      nxt(); instr_ready = 1'b0;
      nxt(); stop = 1'b1;
      nxt(); stop = 1'b0;
      #1; chk("t3_drain", 32'(exp_q.size()), 0);

      // Address wrap 62, 63, 0, 1.
      nxt(); start = 1'b1; start_address = 6'd62; instr_ready = 1'b1;
      push_exp(62); push_exp(63); push_exp(0); push_exp(1);
      nxt(); start = 1'b0;
      #1; chk("t4_addr_c1", 32'(ROM_address), 62);
      nxt();
      nxt(); #1; chk("t4_addr_wrap_c3", 32'(ROM_address), 0);
      repeat (3) nxt();
      nxt(); instr_ready = 1'b0;
      nxt(); stop = 1'b1;
      nxt(); stop = 1'b0;
      #1; chk("t4_drain", 32'(exp_q.size()), 0);

      // Stop with simultaneous branch; branch in IDLE ignored; restart at 10.
      nxt(); start = 1'b1; start_address = 6'd20; instr_ready = 1'b1;
      push_exp(20); push_exp(21);
      nxt(); start = 1'b0;
      repeat (3) nxt();
      nxt(); stop = 1'b1; branch_valid = 1'b1; branch_target = 6'd50;
      #1; chk("t5_rd_stopbr", 32'(ROM_readEnable), 0); chk("t5_valid_stopbr", 32'(instr_valid), 0);
      nxt(); stop = 1'b0; branch_valid = 1'b0;
      #1; chk("t5_busy_after", 32'(busy), 0); chk("t5_rd_after", 32'(ROM_readEnable), 0);
      chk("t5_valid_after", 32'(instr_valid), 0);
      nxt(); branch_valid = 1'b1; branch_target = 6'd30;
      #1; chk("t5_idle_branch_rd", 32'(ROM_readEnable), 0);
      nxt(); branch_valid = 1'b0;
      #1; chk("t5_idle_busy", 32'(busy), 0);
      nxt(); start = 1'b1; start_address = 6'd10;
      push_exp(10); push_exp(11);
      nxt(); start = 1'b0;
      repeat (3) nxt();

      // Asynchronous reset mid-stream with a strobe outstanding.
      nxt(); instr_ready = 1'b0;
      #1; chk("t6_strobe_before", 32'(ROM_readEnable), 1);
      #1 rst = 1'b1;
      #1; chk_reset_vals("t6_async");
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         nxt(); #1;
         chk("t6_no_strobe", 32'(ROM_readEnable), 0);
         chk("t6_no_valid", 32'(instr_valid), 0);
      end
      chk("t6_drain", 32'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/microcode_fetch.md
Name: microcode_fetch

Overview:
- Initiator side of the synchronous microcode ROM interface. Drives ROM_readEnable and ROM_address, and captures ROM_data one cycle after each read.
- Delivers instructions in order to the decoder over a valid/ready handshake, together with each instruction's address.
- Program counter supports start, stop and branch redirect. Holds a small FIFO so decoder back-pressure never loses a ROM word.

Parameters:
- ROM_addressBits, 6, ROM address width; the program counter is this width.
- RF_addressBits, 3, register-file address width; instruction width INSTR_W = 5+2*RF_addressBits (11 at defaults).
- FIFO_DEPTH, 3, instruction buffer entries; legal values are >=3; 3 sustains one instruction per cycle.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begin fetching at start_address (ignored unless IDLE)
- start_address  in  ROM_addressBits  first fetch address
- stop  in  1  abort fetching and return to IDLE
- branch_valid  in  1  redirect fetch this cycle
- branch_target  in  ROM_addressBits  redirect address
- ROM_readEnable  out  1  ROM read strobe
- ROM_address  out  ROM_addressBits  ROM read address
- ROM_data  in  INSTR_W  ROM word; valid the cycle after a read strobe
- instr_valid  out  1  instruction available to decoder
- instr_ready  in  1  decoder accepts
- instr_data  out  INSTR_W  instruction word
- instr_addr  out  ROM_addressBits  ROM address of instr_data
- busy  out  1  high while not IDLE

Behaviour:
- Reset (async, immediate):
  - State is IDLE; pc=0, fifo count=0, pending=0.
  - ROM_readEnable=0, ROM_address=0, instr_valid=0, instr_data=0, instr_addr=0, busy=0.
- State machine has two states, IDLE and RUN.
  - IDLE→RUN on start: pc<=start_address, no read issued in that cycle.
  - RUN→IDLE on stop: FIFO flushed, pending cleared, no read issued in the stop cycle.
  - stop takes priority over branch_valid. start is ignored while in RUN. branch_valid is ignored in IDLE.
- Read issue, RUN only:
  - ROM_readEnable=1 when count+pending+1 <= FIFO_DEPTH. This rule deliberately ignores a same-cycle pop.
  - ROM_address=pc, driven combinationally from the register.
  - On issue, pc<=pc+1 modulo 2**ROM_addressBits, so address 63 is followed by 0. pending<=1; otherwise pending<=0.
  - The address is carried with pending so it is paired with the returning word.
- Capture: when pending=1 and no flush, ROM_data and its address are written to the FIFO tail at the end of that cycle.
- Latency: strobe in cycle t → ROM_data in t+1 → instr_valid in t+2. First instruction appears 3 cycles after the start pulse.
- Handshake:
  - instr_valid = (count!=0) && !branch_valid. instr_data and instr_addr come from the FIFO head.
  - Pop happens when instr_valid && instr_ready. A push and a pop in the same cycle leave count unchanged.
  - instr_data and instr_addr are stable while instr_valid=1 and instr_ready=0.
- Branch cycle, RUN and no stop:
  - FIFO flushed (count<=0). ROM_data arriving that cycle is discarded.
  - No pop occurs; the handshake in the branch cycle is void.
  - A read of branch_target is issued the same cycle: ROM_address=branch_target, ROM_readEnable=1. Then pc<=branch_target+1 (wrapping) and pending<=1.
  - The target instruction is valid 2 cycles later.
- Back-pressure: with instr_ready=0 the FIFO fills to FIFO_DEPTH and the strobe drops. A ROM word is never overwritten or lost.
- Reset asserted mid-fetch discards all in-flight and buffered words.

Decomposition:
- microcode_pkg holds:
  - function instr_w(RF_addressBits)
  - typedef enum {IDLE, RUN} fetch_state_t
  - localparam FIFO_DEPTH_MIN=3
- Sub-module fetch_fifo: synchronous FIFO of {addr, data} entries with push, pop, flush, count and async active-high reset. microcode_fetch holds the PC, FSM and credit logic.

Test Plan:
- Reset then start with start_address=0, ROM[i]=i+100, instr_ready=1 → strobe with addresses 0,1,2,… from cycle 1; instr_valid from cycle 3; instr_data 100,101,102,… one per cycle, with instr_addr matching.
- instr_ready=0 for 10 cycles after the first valid → count saturates at 3, the strobe deasserts, instr_data is held at 100. On releasing ready, 100,101,102,103… arrive with no gap and no duplicate.
- branch_valid with branch_target=40 while words 5 and 6 are buffered → instr_valid=0 in the branch cycle, address 40 is strobed that cycle, the next delivered word is ROM[40] (addr 40) 2 cycles later, and 5 and 6 are never delivered.
- start_address=62 with ready=1 → instr_addr sequence is 62,63,0,1 (wrap-around).
- stop together with branch_valid in the same cycle → busy=0 next cycle, no strobe, instr_valid=0. A later start at 10 delivers ROM[10] first.
- rst asserted asynchronously mid-stream with a strobe outstanding → all outputs are at reset values immediately. After release with no start, ROM_readEnable stays 0.
